// File: rtl/fpu_align_cal_skid_reg_if.sv
// Purpose: align-to-calculate bundle and handshake signals for the FP add/sub pipeline register.
// Latency: none; this file only groups the wires.
// Backpressure: a_ready/c_ready carry the stall, and c_occ reports how many entries are held.
interface fpu_align_cal_skid_reg_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    // upstream (align stage) side
    logic                a_valid;
    logic                a_ready;
    logic [1:0]          a_rm;
    logic                a_is_inf_nan;
    logic [FRAC_W-1:0]   a_inf_nan_frac;
    logic                a_sign;
    logic [EXP_W-1:0]    a_exp;
    logic                a_op_sub;
    logic [FRAC_W:0]     a_large_frac;
    logic [FRAC_W+3:0]   a_small_frac;
    // downstream (calculate stage) side
    logic                c_valid;
    logic                c_ready;
    logic [1:0]          c_rm;
    logic                c_is_inf_nan;
    logic [FRAC_W-1:0]   c_inf_nan_frac;
    logic                c_sign;
    logic [EXP_W-1:0]    c_exp;
    logic                c_op_sub;
    logic [FRAC_W:0]     c_large_frac;
    logic [FRAC_W+3:0]   c_small_frac;
    logic [1:0]          c_occ;

    // pipeline register side
    modport slave (
        input  a_valid, a_rm, a_is_inf_nan, a_inf_nan_frac, a_sign, a_exp, a_op_sub,
               a_large_frac, a_small_frac, c_ready,
        output a_ready, c_valid, c_rm, c_is_inf_nan, c_inf_nan_frac, c_sign, c_exp,
               c_op_sub, c_large_frac, c_small_frac, c_occ
    );

    // surrounding datapath side
    modport master (
        output a_valid, a_rm, a_is_inf_nan, a_inf_nan_frac, a_sign, a_exp, a_op_sub,
               a_large_frac, a_small_frac, c_ready,
        input  a_ready, c_valid, c_rm, c_is_inf_nan, c_inf_nan_frac, c_sign, c_exp,
               c_op_sub, c_large_frac, c_small_frac, c_occ
    );
endinterface

// File: rtl/fpu_align_cal_skid_reg.sv
// Purpose: align-to-calculate pipeline register with a two-entry skid buffer, stage enable and flush.
// Latency: 1 cycle from accept to c_valid when empty; sustains 1 bundle/cycle with c_ready high.
// Backpressure: the skid entry absorbs one beat after c_ready drops; a_ready falls (registered) when both entries are full.
module fpu_align_cal_skid_reg #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                   clock,
    input  logic                   clrn,
    input  logic                   e,
    input  logic                   flush,
    fpu_align_cal_skid_reg_if.slave bus
);

    typedef struct packed {
        logic [1:0]        rm;
        logic              is_inf_nan;
        logic [FRAC_W-1:0] inf_nan_frac;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic              op_sub;
        logic [FRAC_W:0]   large_frac;
        logic [FRAC_W+3:0] small_frac;
    } bundle_t;

    // encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  state_q;
    state_t  state_nxt;
    bundle_t m_q;
    bundle_t s_q;
    bundle_t a_dat;
    logic    rdy_q;
    logic    in_fire;
    logic    out_fire;
    logic    ld_m_a;
    logic    ld_m_s;
    logic    ld_s;

    assign a_dat = {bus.a_rm, bus.a_is_inf_nan, bus.a_inf_nan_frac, bus.a_sign, bus.a_exp,
                    bus.a_op_sub, bus.a_large_frac, bus.a_small_frac};

    // a_ready already includes e, so a frozen stage can never see a transfer
    assign bus.a_ready = rdy_q & e;
    assign bus.c_valid = (state_q != EMPTY) & e;
    assign bus.c_occ   = state_q;
    assign in_fire     = bus.a_valid & bus.a_ready;
    assign out_fire    = bus.c_valid & bus.c_ready;

    // main register feeds the calc stage directly, so no mux sits on the output path
    assign bus.c_rm           = m_q.rm;
    assign bus.c_is_inf_nan   = m_q.is_inf_nan;
    assign bus.c_inf_nan_frac = m_q.inf_nan_frac;
    assign bus.c_sign         = m_q.sign;
    assign bus.c_exp          = m_q.exp;
    assign bus.c_op_sub       = m_q.op_sub;
    assign bus.c_large_frac   = m_q.large_frac;
    assign bus.c_small_frac   = m_q.small_frac;

    // next state and register load selects; flush empties without touching data
    always_comb begin
        state_nxt = state_q;
        ld_m_a    = 1'b0;
        ld_m_s    = 1'b0;
        ld_s      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        ld_m_a    = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_m_a = 1'b1;
                    end else if (in_fire) begin
                        ld_s      = 1'b1;
                        state_nxt = FULL;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        ld_m_s    = 1'b1;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // state and registered ready; ready stays low through reset and rises on the first edge after
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            rdy_q   <= (state_nxt != FULL);
        end
    end

    // bundle storage: main and skid registers load only on real transfers
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (ld_m_a) begin
                m_q <= a_dat;
            end else if (ld_m_s) begin
                m_q <= s_q;
            end
            if (ld_s) begin
                s_q <= a_dat;
            end
        end
    end

endmodule

// File: tb/tb_fpu_align_cal_skid_reg.sv
module tb_fpu_align_cal_skid_reg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int W      = 2 + 1 + FRAC_W + 1 + EXP_W + 1 + (FRAC_W + 1) + (FRAC_W + 4);

    logic clock;
    logic clrn;
    logic e;
    logic flush;

    fpu_align_cal_skid_reg_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();

    fpu_align_cal_skid_reg #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clock (clock),
        .clrn  (clrn),
        .e     (e),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp;
    int n_bad;
    logic [W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] a_pack();
        return {bus.a_rm, bus.a_is_inf_nan, bus.a_inf_nan_frac, bus.a_sign, bus.a_exp,
                bus.a_op_sub, bus.a_large_frac, bus.a_small_frac};
    endfunction

    function automatic logic [W-1:0] c_pack();
        return {bus.c_rm, bus.c_is_inf_nan, bus.c_inf_nan_frac, bus.c_sign, bus.c_exp,
                bus.c_op_sub, bus.c_large_frac, bus.c_small_frac};
    endfunction

    // scoreboard: inputs are stable at the falling edge, so fires seen here happen at the next rising edge
    always @(negedge clock) begin
        if (!clrn) begin
            sb_q.delete();
        end else begin
            if (bus.c_valid && bus.c_ready) begin
                chk("sb_depth", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) chk("sb_bundle", 128'(c_pack()), 128'(sb_q.pop_front()));
            end
            if (flush) begin
                sb_q.delete();
            end else if (bus.a_valid && bus.a_ready && e) begin
                sb_q.push_back(a_pack());
            end
        end
    end

    task automatic set_beat(input logic [EXP_W-1:0] ex);
        bus.a_valid        = 1'b1;
        bus.a_rm           = 2'($urandom);
        bus.a_is_inf_nan   = 1'($urandom);
        bus.a_inf_nan_frac = FRAC_W'($urandom);
        bus.a_sign         = 1'($urandom);
        bus.a_exp          = ex;
        bus.a_op_sub       = 1'($urandom);
        bus.a_large_frac   = (FRAC_W + 1)'($urandom);
        bus.a_small_frac   = (FRAC_W + 4)'($urandom);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clrn = 1'b0;
        e = 1'b1;
        flush = 1'b0;
        bus.c_ready = 1'b1;
        set_beat(8'h00);
        bus.a_valid = 1'b0;

        // reset state
        #12;
        chk("rst_c_valid", 128'(bus.c_valid), 128'(0));
        chk("rst_c_occ", 128'(bus.c_occ), 128'(0));
        chk("rst_a_ready", 128'(bus.a_ready), 128'(0));
        chk("rst_c_dat", 128'(c_pack()), 128'(0));
        @(negedge clock);
        #2;
        clrn = 1'b1;
        #1;
        chk("rel_a_ready_low", 128'(bus.a_ready), 128'(0));
        step();
        chk("rel_a_ready_high", 128'(bus.a_ready), 128'(1));

        // single beat
        set_beat(8'h7F);
        bus.a_large_frac = 24'h800000;
        bus.a_small_frac = 27'h0400001;
        step();
        bus.a_valid = 1'b0;
        chk("one_c_valid", 128'(bus.c_valid), 128'(1));
        chk("one_c_exp", 128'(bus.c_exp), 128'(8'h7F));
        chk("one_large", 128'(bus.c_large_frac), 128'(24'h800000));
        chk("one_small", 128'(bus.c_small_frac), 128'(27'h0400001));
        step();
        chk("one_drain_valid", 128'(bus.c_valid), 128'(0));
        chk("one_drain_occ", 128'(bus.c_occ), 128'(0));

        // streaming 16 beats, no bubbles
        for (int i = 0; i < 16; i++) begin
            set_beat(EXP_W'(i));
            step();
            chk("strm_valid", 128'(bus.c_valid), 128'(1));
            chk("strm_exp", 128'(bus.c_exp), 128'(i));
            chk("strm_a_ready", 128'(bus.a_ready), 128'(1));
        end
        bus.a_valid = 1'b0;
        step();
        chk("strm_end_occ", 128'(bus.c_occ), 128'(0));

        // back-pressure
        bus.c_ready = 1'b0;
        set_beat(8'd1);
        step();
        chk("bp_occ1", 128'(bus.c_occ), 128'(1));
        chk("bp_rdy1", 128'(bus.a_ready), 128'(1));
        set_beat(8'd2);
        step();
        chk("bp_occ2", 128'(bus.c_occ), 128'(2));
        chk("bp_rdy2", 128'(bus.a_ready), 128'(0));
        set_beat(8'd3);
        step();
        chk("bp_hold_occ", 128'(bus.c_occ), 128'(2));
        chk("bp_hold_exp", 128'(bus.c_exp), 128'(1));
        chk("bp_hold_stable", 128'(bus.c_exp), 128'(1));
        bus.c_ready = 1'b1;
        step();
        chk("bp_out2_exp", 128'(bus.c_exp), 128'(2));
        chk("bp_out2_occ", 128'(bus.c_occ), 128'(1));
        chk("bp_out2_rdy", 128'(bus.a_ready), 128'(1));
        step();
        bus.a_valid = 1'b0;
        chk("bp_out3_exp", 128'(bus.c_exp), 128'(3));
        chk("bp_out3_occ", 128'(bus.c_occ), 128'(1));
        step();
        chk("bp_empty", 128'(bus.c_occ), 128'(0));

        // enable freeze with two entries held
        bus.c_ready = 1'b0;
        set_beat(8'd4);
        step();
        set_beat(8'd5);
        step();
        bus.a_valid = 1'b0;
        e = 1'b0;
        bus.c_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_c_valid", 128'(bus.c_valid), 128'(0));
            chk("frz_a_ready", 128'(bus.a_ready), 128'(0));
            chk("frz_occ", 128'(bus.c_occ), 128'(2));
        end
        e = 1'b1;
        #1;
        chk("frz_resume_exp", 128'(bus.c_exp), 128'(4));
        step();
        chk("frz_drain_exp", 128'(bus.c_exp), 128'(5));
        step();
        chk("frz_drain_occ", 128'(bus.c_occ), 128'(0));

        // flush with two held and a pending input beat
        bus.c_ready = 1'b0;
        set_beat(8'd6);
        step();
        set_beat(8'd7);
        step();
        set_beat(8'd8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.a_valid = 1'b0;
        chk("fl_occ", 128'(bus.c_occ), 128'(0));
        chk("fl_c_valid", 128'(bus.c_valid), 128'(0));
        chk("fl_a_ready", 128'(bus.a_ready), 128'(1));
        bus.c_ready = 1'b1;
        step();
        chk("fl_no_deliver", 128'(bus.c_valid), 128'(0));

        // async reset mid-stream
        bus.c_ready = 1'b0;
        set_beat(8'd9);
        step();
        set_beat(8'd10);
        step();
        bus.a_valid = 1'b0;
        chk("ar_pre_occ", 128'(bus.c_occ), 128'(2));
        #2;
        clrn = 1'b0;
        #1;
        chk("ar_c_valid", 128'(bus.c_valid), 128'(0));
        chk("ar_occ", 128'(bus.c_occ), 128'(0));
        chk("ar_c_exp", 128'(bus.c_exp), 128'(0));
        chk("ar_a_ready", 128'(bus.a_ready), 128'(0));
        @(negedge clock);
        #2;
        clrn = 1'b1;
        step();
        chk("ar_rel_rdy", 128'(bus.a_ready), 128'(1));
        bus.c_ready = 1'b1;
        set_beat(8'd11);
        step();
        bus.a_valid = 1'b0;
        chk("ar_new_valid", 128'(bus.c_valid), 128'(1));
        chk("ar_new_exp", 128'(bus.c_exp), 128'(11));
        step();
        chk("ar_new_empty", 128'(bus.c_occ), 128'(0));

        step();
        chk("sb_final_empty", 128'(sb_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
